// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data cache memory port arbiter.
// Holds the state encoding, requester IDs and line geometry.
package mem_arb_pkg;

  localparam int LINE_W = 128;
  localparam int WD_W   = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_I = 2'b01,
    GRANT_D = 2'b10
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Line-wide memory request bus shared by the caches and the memory model.
// Handshake: read/write (with addr/wdata) are held stable until ready; ready is a
// one-cycle completion pulse, and rdata is meaningful only in the ready cycle.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 28
);
  import mem_arb_pkg::*;

  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rdata;
  logic              ready;

  modport master (output read, write, addr, wdata, input rdata, ready);
  modport slave  (input read, write, addr, wdata, output rdata, ready);

endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// Saturating grant watchdog: counts grant cycles without a memory completion and
// flags the cycle in which the TIMEOUT-th such cycle is reached.
module arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic proc_reset_n,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam logic [WD_W-1:0] LIMIT = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] count;

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  // Abort decided in the last allowed cycle, so a grant lasts exactly TIMEOUT cycles.
  assign timeout = (count >= LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the I-cache and
// the D-cache, with ready routing, write-over-read priority and a hang watchdog.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 1023,
  parameter int ADDR_W  = 28
) (
  input  logic               clk,
  input  logic               proc_reset_n,
  mem_port_arbiter_if.slave  i_bus,
  mem_port_arbiter_if.slave  d_bus,
  mem_port_arbiter_if.master mem_bus,
  output logic               arb_err,
  output arb_state_t         dbg_state,
  output req_id_t            dbg_last_grant
);

  arb_state_t        state;
  req_id_t           last_grant;
  req_id_t           granted;
  logic              i_req;
  logic              d_req;
  logic              sel_read;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [LINE_W-1:0] sel_wdata;
  logic              sel_req;
  logic              sel_both;
  logic              wd_timeout;

  assign i_req   = i_bus.read | i_bus.write;
  assign d_req   = d_bus.read | d_bus.write;
  assign granted = (state == GRANT_D) ? REQ_D : REQ_I;

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk          (clk),
    .proc_reset_n (proc_reset_n),
    .clear        (state == IDLE),
    .enable       ((state != IDLE) && !mem_bus.ready),
    .timeout      (wd_timeout)
  );

  // Command mux driven from the registered grant, so reset drops it immediately.
  always_comb begin
    sel_read  = 1'b0;
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    case (state)
      GRANT_I: begin
        sel_read  = i_bus.read;
        sel_write = i_bus.write;
        sel_addr  = i_bus.addr;
        sel_wdata = i_bus.wdata;
      end
      GRANT_D: begin
        sel_read  = d_bus.read;
        sel_write = d_bus.write;
        sel_addr  = d_bus.addr;
        sel_wdata = d_bus.wdata;
      end
      default: ;
    endcase
  end

  assign sel_req  = sel_read | sel_write;
  assign sel_both = sel_read & sel_write;

  assign mem_bus.read  = sel_read & ~sel_write;
  assign mem_bus.write = sel_write;
  assign mem_bus.addr  = sel_addr;
  assign mem_bus.wdata = sel_wdata;

  assign i_bus.ready = (state == GRANT_I) & mem_bus.ready;
  assign d_bus.ready = (state == GRANT_D) & mem_bus.ready;
  assign i_bus.rdata = mem_bus.rdata;
  assign d_bus.rdata = mem_bus.rdata;

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state      <= IDLE;
      last_grant <= REQ_I;
      arb_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req && d_req) begin
            state <= (last_grant == REQ_I) ? GRANT_D : GRANT_I;
          end else if (i_req) begin
            state <= GRANT_I;
          end else if (d_req) begin
            state <= GRANT_D;
          end
        end
        GRANT_I, GRANT_D: begin
          if (sel_both) begin
            arb_err <= 1'b1;
          end
          // Completion wins over a same-cycle withdrawal or timeout.
          if (mem_bus.ready) begin
            last_grant <= granted;
            state      <= IDLE;
          end else if (!sel_req) begin
            state <= IDLE;
          end else if (wd_timeout) begin
            arb_err    <= 1'b1;
            last_grant <= granted;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state      = state;
  assign dbg_last_grant = last_grant;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with a memory model
// and a scoreboard of expected completions per cache plus expected grant order.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W = 28;
  localparam int W      = 1 + ADDR_W + LINE_W;

  logic       clk = 1'b0;
  logic       proc_reset_n = 1'b0;
  logic       arb_err;
  arb_state_t dbg_state;
  req_id_t    dbg_last_grant;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W)) i_bus ();
  mem_port_arbiter_if #(.ADDR_W(ADDR_W)) d_bus ();
  mem_port_arbiter_if #(.ADDR_W(ADDR_W)) mem_bus ();

  mem_port_arbiter #(
    .TIMEOUT (8),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk            (clk),
    .proc_reset_n   (proc_reset_n),
    .i_bus          (i_bus),
    .d_bus          (d_bus),
    .mem_bus        (mem_bus),
    .arb_err        (arb_err),
    .dbg_state      (dbg_state),
    .dbg_last_grant (dbg_last_grant)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    proc_reset_n = 1'b0;
    i_bus.read = 1'b0; i_bus.write = 1'b0;
    d_bus.read = 1'b0; d_bus.write = 1'b0;
    repeat (2) @(negedge clk);
    proc_reset_n = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [W-1:0] exp_i_q[$];
  logic [W-1:0] exp_d_q[$];
  logic         exp_side_q[$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Address 0x10 returns a solid A5 line; other addresses are distinguishable.
  function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_W-1:0] a);
    return {16{8'hA5}} ^ {100'b0, a ^ 28'h0000010};
  endfunction

  // ---------------- memory model ----------------
  int lat      = 2;
  bit hang     = 1'b0;
  bit spurious = 1'b0;
  int busy     = 0;

  initial begin
    mem_bus.ready = 1'b0;
    mem_bus.rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!proc_reset_n) begin
        mem_bus.ready = 1'b0;
        busy = 0;
      end else if ((mem_bus.read || mem_bus.write) && !hang) begin
        if (busy >= lat) begin
          mem_bus.ready = 1'b1;
          mem_bus.rdata = line_of(mem_bus.addr);
          busy = 0;
        end else begin
          mem_bus.ready = 1'b0;
          busy++;
        end
      end else begin
        mem_bus.ready = spurious;
        busy = 0;
      end
    end
  end

  // ---------------- completion monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (i_bus.ready === 1'b1 && d_bus.ready === 1'b1)
        check("dual_ready", W'(1), W'(0));
      if (i_bus.ready === 1'b1) begin
        if (exp_i_q.size() == 0 || exp_side_q.size() == 0)
          check("i_unexpected_ready", W'(1), W'(0));
        else begin
          check("i_order", W'(REQ_I), W'(exp_side_q.pop_front()));
          check("i_txn", {mem_bus.write, mem_bus.addr, mem_bus.write ? mem_bus.wdata : i_bus.rdata},
                exp_i_q.pop_front());
        end
      end
      if (d_bus.ready === 1'b1) begin
        if (exp_d_q.size() == 0 || exp_side_q.size() == 0)
          check("d_unexpected_ready", W'(1), W'(0));
        else begin
          check("d_order", W'(REQ_D), W'(exp_side_q.pop_front()));
          check("d_txn", {mem_bus.write, mem_bus.addr, mem_bus.write ? mem_bus.wdata : d_bus.rdata},
                exp_d_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input logic side, input int limit);
    int n = 0;
    while (((side ? d_bus.ready : i_bus.ready) !== 1'b1) && n < limit) begin
      @(negedge clk);
      #3;
      n++;
    end
    if ((side ? d_bus.ready : i_bus.ready) !== 1'b1)
      check(side ? "d_ready_timeout" : "i_ready_timeout", W'(0), W'(1));
  endtask

  task automatic drive_i(input int n, input logic [ADDR_W-1:0] base);
    logic [ADDR_W-1:0] a;
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      a = base + ADDR_W'(k);
      i_bus.read = 1'b1;
      i_bus.addr = a;
      exp_i_q.push_back({1'b0, a, line_of(a)});
      #3;
      wait_ready(1'b0, 40);
      @(negedge clk);
    end
    i_bus.read = 1'b0;
  endtask

  task automatic drive_d(input int n, input logic [ADDR_W-1:0] base);
    logic [ADDR_W-1:0] a;
    logic [LINE_W-1:0] wd;
    logic              wr;
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      a  = base + ADDR_W'(k);
      wr = k[0];
      wd = {$urandom(), $urandom(), $urandom(), $urandom()};
      d_bus.read  = ~wr;
      d_bus.write = wr;
      d_bus.addr  = a;
      d_bus.wdata = wd;
      exp_d_q.push_back({wr, a, wr ? wd : line_of(a)});
      #3;
      wait_ready(1'b1, 40);
      @(negedge clk);
    end
    d_bus.read  = 1'b0;
    d_bus.write = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [LINE_W-1:0] wd;
    i_bus.read = 1'b0; i_bus.write = 1'b0; i_bus.addr = '0; i_bus.wdata = '0;
    d_bus.read = 1'b0; d_bus.write = 1'b0; d_bus.addr = '0; d_bus.wdata = '0;

    // Reset values
    do_reset();
    #3;
    check("rst_state", W'(dbg_state), W'(IDLE));
    check("rst_last_grant", W'(dbg_last_grant), W'(REQ_I));
    check("rst_err", W'(arb_err), W'(0));
    check("rst_mem_cmd", W'({mem_bus.read, mem_bus.write}), W'(0));
    check("rst_mem_addr", W'(mem_bus.addr), W'(0));
    check("rst_mem_wdata", W'(mem_bus.wdata), W'(0));
    check("rst_ready", W'({i_bus.ready, d_bus.ready}), W'(0));

    // Single I miss, ready three cycles after the request
    @(negedge clk);
    lat = 2;
    i_bus.read = 1'b1;
    i_bus.addr = 28'h0000010;
    exp_side_q.push_back(REQ_I);
    exp_i_q.push_back({1'b0, 28'h0000010, line_of(28'h0000010)});
    #3;
    check("t1_idle_cmd", W'(mem_bus.read), W'(0));
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      #3;
      check("t1_mem_read", W'(mem_bus.read), W'(1));
      check("t1_mem_addr", W'(mem_bus.addr), W'(28'h0000010));
      check("t1_d_ready", W'(d_bus.ready), W'(0));
      check("t1_i_ready", W'(i_bus.ready), W'(c == 3));
    end
    check("t1_i_rdata", W'(i_bus.rdata), W'({16{8'hA5}}));
    @(negedge clk);
    i_bus.read = 1'b0;
    #3;
    check("t1_back_idle", W'(dbg_state), W'(IDLE));
    check("t1_d_ready_after", W'(d_bus.ready), W'(0));

    // Simultaneous requests after reset: D wins, bubble, then I
    do_reset();
    i_bus.read  = 1'b1;
    i_bus.addr  = 28'h0000030;
    d_bus.write = 1'b1;
    d_bus.addr  = 28'h0000020;
    d_bus.wdata = 128'h1234;
    exp_side_q.push_back(REQ_D);
    exp_side_q.push_back(REQ_I);
    exp_d_q.push_back({1'b1, 28'h0000020, 128'h1234});
    exp_i_q.push_back({1'b0, 28'h0000030, line_of(28'h0000030)});
    #3;
    check("t2_idle", W'(dbg_state), W'(IDLE));
    @(negedge clk);
    #3;
    check("t2_grant_d", W'(dbg_state), W'(GRANT_D));
    check("t2_mem_cmd", W'({mem_bus.read, mem_bus.write}), W'(2'b01));
    check("t2_mem_wdata", W'(mem_bus.wdata), W'(128'h1234));
    check("t2_mem_addr", W'(mem_bus.addr), W'(28'h0000020));
    wait_ready(1'b1, 20);
    @(negedge clk);
    d_bus.write = 1'b0;
    #3;
    check("t2_bubble", W'(dbg_state), W'(IDLE));
    check("t2_bubble_cmd", W'({mem_bus.read, mem_bus.write}), W'(0));
    @(negedge clk);
    #3;
    check("t2_grant_i", W'(dbg_state), W'(GRANT_I));
    check("t2_i_addr", W'(mem_bus.addr), W'(28'h0000030));
    wait_ready(1'b0, 20);
    @(negedge clk);
    i_bus.read = 1'b0;

    // Round-robin under continuous requests from both sides
    for (int k = 0; k < 6; k++)
      exp_side_q.push_back((k % 2 == 0) ? REQ_D : REQ_I);
    fork
      drive_i(3, 28'h0000100);
      drive_d(3, 28'h0000200);
    join
    #3;
    check("t3_last_grant", W'(dbg_last_grant), W'(REQ_I));

    // Watchdog: D hangs, grant lasts TIMEOUT cycles, error sticks
    @(negedge clk);
    hang = 1'b1;
    d_bus.read = 1'b1;
    d_bus.addr = 28'h0000040;
    n = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      #3;
      if (dbg_state != GRANT_D) break;
      n++;
      if (n == 1) check("t4_err_during_grant", W'(arb_err), W'(0));
      check("t4_no_d_ready", W'(d_bus.ready), W'(0));
    end
    check("t4_grant_cycles", W'(n), W'(8));
    check("t4_idle", W'(dbg_state), W'(IDLE));
    check("t4_err", W'(arb_err), W'(1));
    check("t4_last_grant", W'(dbg_last_grant), W'(REQ_D));
    d_bus.read = 1'b0;
    hang = 1'b0;
    @(negedge clk);
    i_bus.read = 1'b1;
    i_bus.addr = 28'h0000300;
    exp_side_q.push_back(REQ_I);
    exp_i_q.push_back({1'b0, 28'h0000300, line_of(28'h0000300)});
    #3;
    wait_ready(1'b0, 20);
    @(negedge clk);
    i_bus.read = 1'b0;
    #3;
    check("t4_err_sticky", W'(arb_err), W'(1));

    // Ready in IDLE is ignored, then a granted D drives read and write together
    do_reset();
    spurious = 1'b1;
    #3;
    check("t6_spurious_ready", W'({i_bus.ready, d_bus.ready}), W'(0));
    @(negedge clk);
    #3;
    check("t6_spurious_state", W'(dbg_state), W'(IDLE));
    check("t6_spurious_err", W'(arb_err), W'(0));
    spurious = 1'b0;
    @(negedge clk);
    wd = {$urandom(), $urandom(), $urandom(), $urandom()};
    d_bus.read  = 1'b1;
    d_bus.write = 1'b1;
    d_bus.addr  = 28'h0000060;
    d_bus.wdata = wd;
    exp_side_q.push_back(REQ_D);
    exp_d_q.push_back({1'b1, 28'h0000060, wd});
    @(negedge clk);
    #3;
    check("t6_grant_d", W'(dbg_state), W'(GRANT_D));
    check("t6_mem_cmd", W'({mem_bus.read, mem_bus.write}), W'(2'b01));
    check("t6_mem_wdata", W'(mem_bus.wdata), W'(wd));
    wait_ready(1'b1, 20);
    @(negedge clk);
    d_bus.read  = 1'b0;
    d_bus.write = 1'b0;
    #3;
    check("t6_err", W'(arb_err), W'(1));
    check("t6_last_grant", W'(dbg_last_grant), W'(REQ_D));

    // Reset asserted mid-grant drops the command at once
    @(negedge clk);
    hang = 1'b1;
    i_bus.read = 1'b1;
    i_bus.addr = 28'h0000070;
    @(negedge clk);
    #3;
    check("t5_grant_i", W'(dbg_state), W'(GRANT_I));
    check("t5_mem_read", W'(mem_bus.read), W'(1));
    proc_reset_n = 1'b0;
    #1;
    check("t5_async_drop", W'({mem_bus.read, mem_bus.write}), W'(0));
    check("t5_async_addr", W'(mem_bus.addr), W'(0));
    check("t5_async_state", W'(dbg_state), W'(IDLE));
    check("t5_async_err", W'(arb_err), W'(0));
    check("t5_async_last", W'(dbg_last_grant), W'(REQ_I));
    i_bus.read = 1'b0;
    hang = 1'b0;
    @(negedge clk);
    proc_reset_n = 1'b1;
    #3;
    check("t5_post_state", W'(dbg_state), W'(IDLE));
    check("t5_post_err", W'(arb_err), W'(0));
    check("t5_post_last", W'(dbg_last_grant), W'(REQ_I));

    @(negedge clk);
    #3;
    check("exp_q_empty", W'(exp_i_q.size() + exp_d_q.size() + exp_side_q.size()), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- global time bound ----------------
  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL global_timeout: got running expected finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
